// File: rtl/se_scale_sequencer_if.sv
// Bus bundle between the SE scale sequencer, the feature-map memory, the
// configuration/FC2 source and the downstream SE multiplier array.
interface se_scale_sequencer_if #(
  parameter int bitsize       = 14,
  parameter int NUM_INSTANCES = 16
);
  logic                               cfg_start;
  logic [6:0]                         cfg_num_groups;
  logic [12:0]                        cfg_num_pixels;
  logic [bitsize*NUM_INSTANCES-1:0]   fc_in;
  logic                               fc_valid;
  logic                               fm_rd_en;
  logic [12:0]                        fm_rd_addr;
  logic [bitsize*NUM_INSTANCES-1:0]   fm_rd_data;
  logic [bitsize*NUM_INSTANCES-1:0]   data_in;
  logic [bitsize*NUM_INSTANCES-1:0]   weights;
  logic                               start_flag;
  logic [12:0]                        in_address;
  logic                               busy;
  logic                               done;

  modport master (
    input  cfg_start, cfg_num_groups, cfg_num_pixels, fc_in, fc_valid, fm_rd_data,
    output fm_rd_en, fm_rd_addr, data_in, weights, start_flag, in_address, busy, done
  );

  modport slave (
    output cfg_start, cfg_num_groups, cfg_num_pixels, fc_in, fc_valid, fm_rd_data,
    input  fm_rd_en, fm_rd_addr, data_in, weights, start_flag, in_address, busy, done
  );
endinterface

// File: rtl/se_scale_sequencer.sv
// SE scale sequencer: converts FC2 words to hard-sigmoid scales in a per-group
// bank, then streams feature-map words paired with their group scale word to
// the SE multiplier array at one word per cycle.
module se_scale_sequencer #(
  parameter int bitsize       = 14,
  parameter int FRAC_BITS     = 7,
  parameter int NUM_INSTANCES = 16,
  parameter int MAX_GROUPS    = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  se_scale_sequencer_if.master bus
);
  localparam int W  = bitsize * NUM_INSTANCES;
  localparam int GW = $clog2(MAX_GROUPS);
  localparam int SW = bitsize + 2;
  localparam logic signed [SW-1:0] HSIG_OFS = SW'(3 << FRAC_BITS);
  localparam logic signed [SW-1:0] HSIG_MAX = SW'(6 << FRAC_BITS);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;

  state_t        r_state;
  logic [6:0]    r_num_groups;
  logic [12:0]   r_num_pixels;
  logic [GW-1:0] r_load_ptr;
  logic [GW-1:0] r_grp;
  logic [12:0]   r_pix;
  logic [12:0]   r_addr;
  logic [12:0]   r_in_address;
  logic [W-1:0]  r_weights;
  logic          r_rd_en;
  logic          r_start;
  logic          r_done;
  logic [W-1:0]  r_bank [MAX_GROUPS];

  logic [W-1:0]  w_hsig;
  logic          w_load_last;
  logic          w_pix_last;
  logic          w_grp_last;

  // Hard sigmoid on one Q6.7 lane: clamp(x+3,0,6)/6, rounded, result 0..128.
  function automatic logic [bitsize-1:0] hsig_lane(input logic [bitsize-1:0] x);
    logic signed [SW-1:0] v;
    logic [24:0]          t;
    logic [24:0]          prod;
    v = SW'(signed'(x)) + HSIG_OFS;
    if (v < 0)             t = '0;
    else if (v > HSIG_MAX) t = 25'(HSIG_MAX);
    else                   t = 25'(v);
    prod = t * 25'd21845 + 25'd65536;
    return bitsize'(prod >> 17);
  endfunction

  // Per-lane scale conversion of the incoming FC2 word.
  always_comb begin
    w_hsig = '0;
    for (int unsigned i = 0; i < NUM_INSTANCES; i++) begin
      w_hsig[i*bitsize +: bitsize] = hsig_lane(bus.fc_in[i*bitsize +: bitsize]);
    end
  end

  assign w_load_last = (7'(r_load_ptr) == r_num_groups - 7'd1);
  assign w_pix_last  = (r_pix == r_num_pixels - 13'd1);
  assign w_grp_last  = (7'(r_grp) == r_num_groups - 7'd1);

  // Scale bank write during LOAD; deliberately not reset so scales persist.
  always_ff @(posedge clk) begin
    if (r_state == LOAD && bus.fc_valid) begin
      r_bank[r_load_ptr] <= w_hsig;
    end
  end

  // Control FSM with registered multiplier-side outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_num_groups <= '0;
      r_num_pixels <= '0;
      r_load_ptr   <= '0;
      r_grp        <= '0;
      r_pix        <= '0;
      r_addr       <= '0;
      r_in_address <= '0;
      r_weights    <= '0;
      r_rd_en      <= 1'b0;
      r_start      <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_start <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.cfg_start) begin
            r_num_groups <= (bus.cfg_num_groups > 7'(MAX_GROUPS)) ? 7'(MAX_GROUPS)
                                                                  : bus.cfg_num_groups;
            r_num_pixels <= bus.cfg_num_pixels;
            r_load_ptr   <= '0;
            if (bus.cfg_num_groups == 7'd0 || bus.cfg_num_pixels == 13'd0) begin
              r_done <= 1'b1;
            end else begin
              r_state <= LOAD;
            end
          end
        end
        LOAD: begin
          if (bus.fc_valid) begin
            r_load_ptr <= r_load_ptr + GW'(1);
            if (w_load_last) begin
              r_state <= RUN;
              r_addr  <= '0;
              r_pix   <= '0;
              r_grp   <= '0;
              r_rd_en <= 1'b1;
            end
          end
        end
        RUN: begin
          // Read issued this cycle; scale/address line up with the returning data next cycle.
          r_start      <= 1'b1;
          r_weights    <= r_bank[r_grp];
          r_in_address <= r_addr;
          r_addr       <= r_addr + 13'd1;
          if (w_pix_last) begin
            r_pix <= '0;
            r_grp <= r_grp + GW'(1);
          end else begin
            r_pix <= r_pix + 13'd1;
          end
          if (w_pix_last && w_grp_last) begin
            r_state <= DRAIN;
            r_rd_en <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        DRAIN:   r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.fm_rd_en   = r_rd_en;
  assign bus.fm_rd_addr = r_addr;
  assign bus.data_in    = bus.fm_rd_data;
  assign bus.weights    = r_weights;
  assign bus.start_flag = r_start;
  assign bus.in_address = r_in_address;
  assign bus.busy       = (r_state != IDLE);
  assign bus.done       = r_done;
endmodule

// File: tb/tb_se_scale_sequencer.sv
// Bench for se_scale_sequencer: a hsig table plus layer sequences checked by
// an expected-word queue consumed on every start_flag cycle.
module tb_se_scale_sequencer;
  localparam int BS = 14;
  localparam int NI = 16;
  localparam int W  = BS * NI;
  localparam int MG = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  se_scale_sequencer_if #(.bitsize(BS), .NUM_INSTANCES(NI)) bus ();

  se_scale_sequencer #(
    .bitsize(BS), .FRAC_BITS(7), .NUM_INSTANCES(NI), .MAX_GROUPS(MG)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct { int x; int s; } hsig_vec_t;
  typedef struct {
    logic [12:0]  addr;
    logic [W-1:0] wt;
    logic [W-1:0] dat;
    logic         last;
  } exp_t;

  hsig_vec_t    tbl [NI];
  exp_t         sb_q [$];
  bit           sb_active = 1'b0;
  logic [W-1:0] fc_words [MG+4];
  logic [W-1:0] cap_w;
  int           n_vec = 0;
  int           n_bad = 0;
  int           rd_cnt = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int hsig_ref(input int x);
    int t = x + 384;
    if (t < 0)   t = 0;
    if (t > 768) t = 768;
    return (t * 21845 + 65536) >> 17;
  endfunction

  function automatic logic [W-1:0] hsig_word(input logic [W-1:0] f);
    logic [W-1:0] r;
    for (int i = 0; i < NI; i++) begin
      logic signed [BS-1:0] l;
      l = f[i*BS +: BS];
      r[i*BS +: BS] = BS'(hsig_ref(int'(l)));
    end
    return r;
  endfunction

  function automatic logic [W-1:0] mem_word(input logic [12:0] a);
    logic [W-1:0] r;
    for (int i = 0; i < NI; i++) r[i*BS +: BS] = BS'(int'(a) + i * 3);
    return r;
  endfunction

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] r;
    for (int i = 0; i < NI; i++) r[i*BS +: BS] = BS'(int'($urandom_range(0, 1500)) - 600);
    return r;
  endfunction

  // Feature-map memory: data returns one cycle after the read strobe.
  always @(posedge clk) begin
    if (bus.fm_rd_en === 1'b1) begin
      bus.fm_rd_data <= mem_word(bus.fm_rd_addr);
      rd_cnt         <= rd_cnt + 1;
    end
  end

  // Scoreboard consumer: every start_flag cycle must match the next expected word.
  always @(negedge clk) begin
    exp_t e;
    if (rst !== 1'b1) begin
      if (bus.start_flag === 1'b1) begin
        if (sb_q.size() == 0) begin
          check("start_flag_unexpected", W'(bus.start_flag), '0);
        end else begin
          e = sb_q.pop_front();
          check("in_address", W'(bus.in_address), W'(e.addr));
          check("weights", bus.weights, e.wt);
          check("data_in", bus.data_in, e.dat);
          check("done_with_word", W'(bus.done), W'(e.last));
          cap_w     = bus.weights;
          sb_active = !e.last;
        end
      end else if (sb_active) begin
        check("start_flag_gap", W'(bus.start_flag), W'(1));
      end
    end
  end

  task automatic push_expected(input int g, input int p);
    exp_t e;
    for (int k = 0; k < g * p; k++) begin
      e.addr = 13'(k);
      e.wt   = hsig_word(fc_words[k / p]);
      e.dat  = mem_word(13'(k));
      e.last = (k == g * p - 1);
      sb_q.push_back(e);
    end
  endtask

  task automatic start_cfg(input int g, input int p);
    @(negedge clk);
    bus.cfg_num_groups = 7'(g);
    bus.cfg_num_pixels = 13'(p);
    bus.cfg_start      = 1'b1;
    @(negedge clk);
    bus.cfg_start = 1'b0;
  endtask

  // Streams n FC words back to back; checks that RUN starts right after word g_eff.
  task automatic load_words(input int n, input int g_eff, input bit inject);
    for (int i = 0; i < n; i++) begin
      bus.fc_in    = fc_words[i];
      bus.fc_valid = 1'b1;
      if (inject && i == n - 1) begin
        bus.cfg_num_groups = 7'd1;
        bus.cfg_num_pixels = 13'd1;
        bus.cfg_start      = 1'b1;
      end
      @(negedge clk);
      if (i == g_eff - 1) begin
        #1;
        check("run_rd_en", W'(bus.fm_rd_en), W'(1));
        check("run_rd_addr", W'(bus.fm_rd_addr), '0);
        check("run_no_start_yet", W'(bus.start_flag), '0);
      end
    end
    bus.fc_valid  = 1'b0;
    bus.cfg_start = 1'b0;
  endtask

  task automatic wait_words(input int budget);
    int t = 0;
    while ((sb_q.size() != 0 || sb_active) && t < budget) begin
      @(negedge clk); #1;
      t++;
    end
    if (sb_q.size() != 0 || sb_active) begin
      check("layer_timeout", W'(sb_q.size()) + W'(sb_active), '0);
      sb_q.delete();
      sb_active = 1'b0;
    end
  endtask

  task automatic idle_check();
    @(negedge clk); #1;
    check("idle_busy", W'(bus.busy), '0);
    check("idle_start_flag", W'(bus.start_flag), '0);
    check("idle_done", W'(bus.done), '0);
    check("idle_rd_en", W'(bus.fm_rd_en), '0);
  endtask

  task automatic run_layer(input int g, input int p, input int nvalid, input bit inject);
    int g_eff = (g > MG) ? MG : g;
    push_expected(g_eff, p);
    start_cfg(g, p);
    load_words(nvalid, g_eff, inject);
    wait_words(g_eff * p + 50);
  endtask

  task automatic zero_cfg(input int g, input int p);
    int rd0 = rd_cnt;
    start_cfg(g, p);
    check("zero_done_pulse", W'(bus.done), W'(1));
    check("zero_busy", W'(bus.busy), '0);
    @(negedge clk);
    check("zero_done_drop", W'(bus.done), '0);
    repeat (3) @(negedge clk);
    check("zero_no_reads", W'(rd_cnt - rd0), '0);
  endtask

  initial begin
    int t;
    tbl = '{'{-512, 0}, '{-384, 0}, '{0, 64}, '{384, 128}, '{640, 128}, '{128, 85},
            '{-8192, 0}, '{8191, 128}, '{-383, 0}, '{-128, 43}, '{256, 107}, '{383, 128},
            '{1, 64}, '{-1, 64}, '{64, 75}, '{-256, 21}};
    rst = 1'b1;
    bus.cfg_start = 1'b0;
    bus.cfg_num_groups = '0;
    bus.cfg_num_pixels = '0;
    bus.fc_in = '0;
    bus.fc_valid = 1'b0;
    #3;
    check("rst_rd_en", W'(bus.fm_rd_en), '0);
    check("rst_rd_addr", W'(bus.fm_rd_addr), '0);
    check("rst_weights", bus.weights, '0);
    check("rst_start_flag", W'(bus.start_flag), '0);
    check("rst_in_address", W'(bus.in_address), '0);
    check("rst_busy", W'(bus.busy), '0);
    check("rst_done", W'(bus.done), '0);
    @(negedge clk);
    rst = 1'b0;

    // hsig table: one word carrying every table input, one group, one pixel.
    for (int i = 0; i < NI; i++) fc_words[0][i*BS +: BS] = BS'(tbl[i].x);
    run_layer(1, 1, 1, 1'b0);
    idle_check();
    for (int i = 0; i < NI; i++) begin
      check($sformatf("hsig_lane%0d_x%0d", i, tbl[i].x), W'(cap_w[i*BS +: BS]), W'(tbl[i].s));
    end

    // Two groups of three pixels, then a back-to-back layer in the cycle after done.
    fc_words[0] = rand_word();
    fc_words[1] = rand_word();
    run_layer(2, 3, 2, 1'b0);
    fc_words[0] = rand_word();
    run_layer(1, 2, 1, 1'b0);
    idle_check();

    zero_cfg(0, 5);
    zero_cfg(2, 0);

    // fc_valid held past the group count, with a cfg_start landing in RUN.
    for (int i = 0; i < 5; i++) fc_words[i] = rand_word();
    run_layer(3, 2, 5, 1'b1);
    idle_check();

    // Group count above the bank depth clamps to 64.
    for (int i = 0; i < MG + 2; i++) fc_words[i] = rand_word();
    run_layer(127, 1, MG + 2, 1'b0);
    idle_check();

    // Asynchronous reset after 4 of 12 words.
    for (int i = 0; i < 3; i++) fc_words[i] = rand_word();
    push_expected(3, 4);
    start_cfg(3, 4);
    load_words(3, 3, 1'b0);
    t = 0;
    while (sb_q.size() > 8 && t < 50) begin @(negedge clk); #1; t++; end
    check("rst_mid_words_seen", W'(sb_q.size()), W'(8));
    #2 rst = 1'b1;
    #1;
    check("rst_mid_start_flag", W'(bus.start_flag), '0);
    check("rst_mid_busy", W'(bus.busy), '0);
    check("rst_mid_rd_en", W'(bus.fm_rd_en), '0);
    check("rst_mid_done", W'(bus.done), '0);
    sb_q.delete();
    sb_active = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) fc_words[i] = rand_word();
    run_layer(3, 4, 3, 1'b0);
    idle_check();

    // Full address space: 64 groups x 128 pixels.
    for (int i = 0; i < MG; i++) fc_words[i] = rand_word();
    run_layer(64, 128, MG, 1'b0);
    idle_check();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad + 1);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/se_scale_sequencer.md
# se_scale_sequencer

Sequencer that sits directly upstream of the SE multiplier array. It first converts the 16-lane FC2 outputs of the squeeze path into hard-sigmoid channel scales and stores them in a per-group scale bank. It then streams the feature map from memory, pairing each 16-channel pixel word with its group's scale word. It drives the multiplier's data, weights, start_flag and in_address inputs once per cycle, without bubbles.

## Interface
- bitsize, 14, lane width (signed fixed point)
- FRAC_BITS, 7, fractional bits (Q6.7)
- NUM_INSTANCES, 16, lanes (channels) per word
- MAX_GROUPS, 64, scale bank depth (channel groups)
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- cfg_start  in  1  one-cycle pulse; latches configuration, begins load phase
- cfg_num_groups  in  7  channel groups (words) per layer
- cfg_num_pixels  in  13  pixels per channel group
- fc_in  in  bitsize*NUM_INSTANCES  FC2 output word, lane i = bits [i*bitsize +: bitsize]
- fc_valid  in  1  fc_in valid
- fm_rd_en  out  1  feature-map read strobe
- fm_rd_addr  out  13  feature-map read address
- fm_rd_data  in  bitsize*NUM_INSTANCES  read data, valid exactly 1 cycle after fm_rd_en
- data_in  out  bitsize*NUM_INSTANCES  to multiplier; combinational pass of fm_rd_data
- weights  out  bitsize*NUM_INSTANCES  to multiplier; registered scale word
- start_flag  out  1  to multiplier; data_in/weights/in_address valid
- in_address  out  13  to multiplier; address of the current pixel word
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse at end of layer

## Operation
- States: IDLE, LOAD, RUN, DRAIN.
- IDLE:
  - On cfg_start, latch the configuration. cfg_num_groups above MAX_GROUPS is clamped to MAX_GROUPS.
  - Clear load_ptr, then go to LOAD.
  - If either latched count is 0, pulse done in the next cycle and stay in IDLE.
- LOAD:
  - Each fc_valid cycle writes hsig(fc_in) to scale_bank[load_ptr], then increments load_ptr.
  - After the write with load_ptr == num_groups-1, go to RUN with addr = 0, pix = 0, grp = 0.
- hsig, per lane: t = clamp(x + 384, 0, 768), where 384 = 3.0 and 768 = 6.0 in Q7; s = (t*21845 + 65536) >> 17. Result range is 0..128. Lane output is s zero-extended to bitsize.
- RUN, every cycle:
  - Drive fm_rd_en=1 and fm_rd_addr=addr.
  - Register weights <= scale_bank[grp] and in_address <= addr; set start_flag=1 in the next cycle.
  - Increment addr (13-bit, wraps mod 8192).
  - When pix == num_pixels-1: set pix = 0 and grp++; otherwise pix++.
  - After issuing the last word (grp == num_groups-1 and pix == num_pixels-1), go to DRAIN.
- DRAIN: one cycle. start_flag=1 for the final word, done=1, then go to IDLE.
- Ignored inputs:
  - fc_valid outside LOAD.
  - cfg_start outside IDLE.
  - fc_valid words beyond num_groups.
- The scale bank is not reset; its contents persist across layers.

## Timing
- Reset values: fm_rd_en=0, fm_rd_addr=0, weights=0, start_flag=0, in_address=0, busy=0, done=0. State is IDLE.
- Reset in any state returns the block to IDLE at once. start_flag drops asynchronously. No done pulse is generated.
- Load: 1 cycle per fc_valid word, with no backpressure.
- RUN, per word:
  - fm_rd_en issued at cycle T.
  - start_flag, weights, in_address and data_in are valid at T+1.
- Throughput: 1 word per cycle, num_groups*num_pixels consecutive start_flag cycles with no gaps.
- done is high in the same cycle as the last start_flag. busy falls one cycle later.
- A cfg_start in the cycle after done is accepted.

## Test plan
- hsig lanes, x = -512, -384, 0, 384, 640: scale = 0, 0, 64, 128, 128. Also x = 128 (1.0): t = 512, s = 85.
- Config groups=2, pixels=3; load fc words A, B; memory word at addr k = k:
  - start_flag is high for 6 consecutive cycles.
  - in_address = 0..5.
  - weights = hsig(A) for addresses 0–2 and hsig(B) for addresses 3–5.
  - done is high with the 6th word.
- groups=0 or pixels=0: no fm_rd_en, no start_flag, done pulse 1 cycle after cfg_start.
- fc_valid held for 5 cycles with groups=3: only 3 words are stored. RUN begins the cycle after the 3rd word. cfg_start asserted during RUN is ignored.
- rst asserted mid-RUN (after 4 of 12 words): start_flag, busy and fm_rd_en go to 0 immediately. A new cfg_start then reloads and runs a complete layer.
- groups=64, pixels=128 (8192 words): in_address runs 0..8191 with no gaps. weights change every 128 words. done is high at address 8191.
